// File: rtl/speaker_gain_pkg.sv
// Shared constants, FSM state types and register helpers for the speaker gain
// AXI4-Lite block.
package speaker_gain_pkg;

   localparam int          GAIN_STRIDE = 4;
   localparam int          ADDR_LSB    = $clog2(GAIN_STRIDE);
   localparam int          GAIN_FRAC   = 14;
   localparam int          GAIN_W      = 16;
   localparam logic [31:0] GAIN_RESET  = 32'h0000_4000;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   // Merge a write into a 32-bit register honouring the byte-lane strobes.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/gain_sat_mul.sv
// Two-stage signed sample x unsigned Q2.14 gain pipeline: stage 1 multiplies,
// stage 2 shifts down and saturates. Channel and valid ride alongside.
module gain_sat_mul
   import speaker_gain_pkg::*;
#(
   parameter int SAMPLE_W = 24,
   parameter int CH_W     = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [SAMPLE_W-1:0] in_sample,
   input  logic [GAIN_W-1:0]   gain,
   output logic                out_valid,
   output logic [CH_W-1:0]     out_ch,
   output logic [SAMPLE_W-1:0] out_sample
);

   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic signed [PROD_W-1:0] mul_a, mul_b;
   logic signed [PROD_W-1:0] s1_prod;
   logic                     s1_valid;
   logic [CH_W-1:0]          s1_ch;
   logic signed [PROD_W-1:0] shifted;
   logic [PROD_W-SAMPLE_W:0] shifted_top;
   logic [SAMPLE_W-1:0]      sat_sample;

   // Gain is unsigned: zero-extend it, sign-extend the sample.
   assign mul_a = PROD_W'($signed(in_sample));
   assign mul_b = {{(PROD_W-GAIN_W){1'b0}}, gain};

   assign shifted     = s1_prod >>> GAIN_FRAC;
   assign shifted_top = shifted[PROD_W-1:SAMPLE_W-1];

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      sat_sample = shifted[SAMPLE_W-1:0];
      if (!(&shifted_top) && (|shifted_top)) begin
         sat_sample = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_ch      <= '0;
         s1_prod    <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_sample <= '0;
      end else begin
         s1_valid  <= in_valid;
         s1_ch     <= in_ch;
         s1_prod   <= mul_a * mul_b;
         out_valid <= s1_valid;
         out_ch    <= s1_ch;
         if (s1_valid) out_sample <= sat_sample;
      end
   end

endmodule

// File: rtl/speaker_gain_axil_slave.sv
// AXI4-Lite register file of per-channel speaker gains feeding a frame-coherent
// gain/saturation pipeline on the time-multiplexed sample stream.
module speaker_gain_axil_slave
   import speaker_gain_pkg::*;
#(
   parameter  int C_S_AXI_DATA_WIDTH = 32,
   parameter  int C_S_AXI_ADDR_WIDTH = 4,
   parameter  int NUM_CH             = 4,
   parameter  int SAMPLE_W           = 24,
   localparam int CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            in_valid,
   input  logic [CH_W-1:0]                 in_ch,
   input  logic [SAMPLE_W-1:0]             in_sample,
   output logic                            out_valid,
   output logic [CH_W-1:0]                 out_ch,
   output logic [SAMPLE_W-1:0]             out_sample
);

   localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

   logic [C_S_AXI_DATA_WIDTH-1:0] gain_regs   [NUM_CH];
   logic [GAIN_W-1:0]             active_gain [NUM_CH];

   w_state_t        w_state, w_state_nxt;
   r_state_t        r_state, r_state_nxt;
   logic            wr_accept, rd_accept;
   logic [CH_W-1:0] wr_idx, rd_idx;
   logic            wr_hit, rd_hit, ch_hit;
   logic [GAIN_W-1:0] sample_gain;
   logic            unused_inputs;

   // Only the word index is decoded; byte offset and upper bits alias.
   assign wr_idx = S_AXI_AWADDR[ADDR_LSB +: CH_W];
   assign rd_idx = S_AXI_ARADDR[ADDR_LSB +: CH_W];
   assign wr_hit = {1'b0, wr_idx} < NUM_CH_W;
   assign rd_hit = {1'b0, rd_idx} < NUM_CH_W;
   assign ch_hit = {1'b0, in_ch}  < NUM_CH_W;

   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // Write channel: AW and W are taken together in one cycle, never one alone.
   always_comb begin
      w_state_nxt = w_state;
      wr_accept   = 1'b0;
      case (w_state)
         W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wr_accept   = 1'b1;
            w_state_nxt = W_RESP;
         end
         W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      rd_accept   = 1'b0;
      case (r_state)
         R_IDLE: if (S_AXI_ARVALID) begin
            rd_accept   = 1'b1;
            r_state_nxt = R_DATA;
         end
         R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
      end
   end

   assign S_AXI_AWREADY = wr_accept;
   assign S_AXI_WREADY  = wr_accept;
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = rd_accept;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign S_AXI_RRESP   = RESP_OKAY;

   // NOTE: the gain register file must power up at unity, so it is reset like any other flop.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_CH; k++) gain_regs[k] <= GAIN_RESET;
      end else if (wr_accept && wr_hit) begin
         gain_regs[wr_idx] <= apply_wstrb(gain_regs[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);
      end
   end

   // A same-cycle write is not visible here: the read captures the pre-edge value.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_RDATA <= '0;
      end else if (rd_accept) begin
         S_AXI_RDATA <= rd_hit ? gain_regs[rd_idx] : '0;
      end
   end

   // Snapshot all gains at channel 0 so a frame never mixes old and new gains.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_CH; k++) active_gain[k] <= GAIN_RESET[GAIN_W-1:0];
      end else if (in_valid && in_ch == '0) begin
         for (int k = 0; k < NUM_CH; k++) active_gain[k] <= gain_regs[k][GAIN_W-1:0];
      end
   end

   // Channel 0 uses the value being snapshotted this cycle; unknown channels are muted.
   always_comb begin
      sample_gain = '0;
      if (ch_hit) begin
         if (in_ch == '0) sample_gain = gain_regs[0][GAIN_W-1:0];
         else             sample_gain = active_gain[in_ch];
      end
   end

   gain_sat_mul #(
      .SAMPLE_W (SAMPLE_W),
      .CH_W     (CH_W)
   ) u_gain_sat_mul (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .in_valid   (in_valid),
      .in_ch      (in_ch),
      .in_sample  (in_sample),
      .gain       (sample_gain),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_sample (out_sample)
   );

endmodule

// File: tb/tb_speaker_gain_axil_slave.sv
// Self-checking bench for speaker_gain_axil_slave: register vectors, AXI
// back-pressure and reset sequences, and a scoreboard on the sample stream.
module tb_speaker_gain_axil_slave;

   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = 24;
   localparam int CH_W     = 2;

   logic                tb_ACLK = 1'b0;
   logic                tb_ARESETN;
   logic [3:0]          s_axi_awaddr;
   logic [2:0]          s_axi_awprot;
   logic                s_axi_awvalid, s_axi_awready;
   logic [31:0]         s_axi_wdata;
   logic [3:0]          s_axi_wstrb;
   logic                s_axi_wvalid, s_axi_wready;
   logic [1:0]          s_axi_bresp;
   logic                s_axi_bvalid, s_axi_bready;
   logic [3:0]          s_axi_araddr;
   logic [2:0]          s_axi_arprot;
   logic                s_axi_arvalid, s_axi_arready;
   logic [31:0]         s_axi_rdata;
   logic [1:0]          s_axi_rresp;
   logic                s_axi_rvalid, s_axi_rready;
   logic                in_valid;
   logic [CH_W-1:0]     in_ch;
   logic [SAMPLE_W-1:0] in_sample;
   logic                out_valid;
   logic [CH_W-1:0]     out_ch;
   logic [SAMPLE_W-1:0] out_sample;

   always #5 tb_ACLK = ~tb_ACLK;

   speaker_gain_axil_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .NUM_CH             (NUM_CH),
      .SAMPLE_W           (SAMPLE_W)
   ) dut (
      .ACLK          (tb_ACLK),
      .ARESETN       (tb_ARESETN),
      .S_AXI_AWADDR  (s_axi_awaddr),
      .S_AXI_AWPROT  (s_axi_awprot),
      .S_AXI_AWVALID (s_axi_awvalid),
      .S_AXI_AWREADY (s_axi_awready),
      .S_AXI_WDATA   (s_axi_wdata),
      .S_AXI_WSTRB   (s_axi_wstrb),
      .S_AXI_WVALID  (s_axi_wvalid),
      .S_AXI_WREADY  (s_axi_wready),
      .S_AXI_BRESP   (s_axi_bresp),
      .S_AXI_BVALID  (s_axi_bvalid),
      .S_AXI_BREADY  (s_axi_bready),
      .S_AXI_ARADDR  (s_axi_araddr),
      .S_AXI_ARPROT  (s_axi_arprot),
      .S_AXI_ARVALID (s_axi_arvalid),
      .S_AXI_ARREADY (s_axi_arready),
      .S_AXI_RDATA   (s_axi_rdata),
      .S_AXI_RRESP   (s_axi_rresp),
      .S_AXI_RVALID  (s_axi_rvalid),
      .S_AXI_RREADY  (s_axi_rready),
      .in_valid      (in_valid),
      .in_ch         (in_ch),
      .in_sample     (in_sample),
      .out_valid     (out_valid),
      .out_ch        (out_ch),
      .out_sample    (out_sample)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [CH_W-1:0]     ch;
      logic [SAMPLE_W-1:0] sample;
   } exp_t;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rd;
   } reg_vec_t;

   typedef struct {
      logic [15:0]         gain;
      logic [SAMPLE_W-1:0] sample;
      logic [SAMPLE_W-1:0] exp_out;
   } smp_vec_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] model_regs   [NUM_CH];
   logic [15:0] model_active [NUM_CH];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [SAMPLE_W-1:0] model_scale(input logic [SAMPLE_W-1:0] s, input logic [15:0] g);
      longint sv, p, q;
      sv = longint'($signed(s));
      p  = sv * longint'(g);
      q  = p / 16384;
      if (p < 0 && (p % 16384) != 0) q = q - 1;
      if (q > 64'sd8388607)       q = 64'sd8388607;
      else if (q < -64'sd8388608) q = -64'sd8388608;
      return q[SAMPLE_W-1:0];
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                               input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // Scoreboard: every out_valid must match the oldest pending expectation.
   always @(negedge tb_ACLK) begin
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("out_ch", {30'b0, out_ch}, {30'b0, mon_e.ch});
            check("out_sample", {8'b0, out_sample}, {8'b0, mon_e.sample});
         end
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge tb_ACLK);
         #1;
      end
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit done;
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         done = s_axi_awready && s_axi_wready;
         @(posedge tb_ACLK);
         #1;
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      check("aw/w handshake", {31'b0, done}, 32'd1);
      if (done) model_regs[addr[3:2]] = model_merge(model_regs[addr[3:2]], data, strb);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         if (s_axi_bvalid) begin
            done = 1'b1;
            check("bresp", {30'b0, s_axi_bresp}, 32'd0);
         end
         @(posedge tb_ACLK);
         #1;
      end
      check("b handshake", {31'b0, done}, 32'd1);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      bit done;
      s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      data = 32'hxxxx_xxxx;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         done = s_axi_arready;
         @(posedge tb_ACLK);
         #1;
      end
      s_axi_arvalid = 1'b0;
      check("ar handshake", {31'b0, done}, 32'd1);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         if (s_axi_rvalid) begin
            done = 1'b1;
            data = s_axi_rdata;
            check("rresp", {30'b0, s_axi_rresp}, 32'd0);
         end
         @(posedge tb_ACLK);
         #1;
      end
      check("r handshake", {31'b0, done}, 32'd1);
   endtask

   // Drives one sample for one cycle and queues its expected output.
   task automatic drive_sample(input logic [CH_W-1:0] ch, input logic [SAMPLE_W-1:0] s,
                               input logic [SAMPLE_W-1:0] exp_fixed, input bit use_model);
      exp_t e;
      if (ch == 0) begin
         for (int k = 0; k < NUM_CH; k++) model_active[k] = model_regs[k][15:0];
      end
      e.ch     = ch;
      e.sample = use_model ? model_scale(s, model_active[ch]) : exp_fixed;
      sb_q.push_back(e);
      in_valid = 1'b1; in_ch = ch; in_sample = s;
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         model_regs[k]   = 32'h0000_4000;
         model_active[k] = 16'h4000;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
      $fatal(1);
   end

   initial begin
      reg_vec_t    rvec[7];
      smp_vec_t    svec[11];
      logic [31:0] rd;
      logic [31:0] old_val;
      bit          done;

      rvec[0] = '{4'h0, 32'h0101_FFFF, 4'hF, 32'h0101_FFFF};
      rvec[1] = '{4'h4, 32'hABCD_0001, 4'hF, 32'hABCD_0001};
      rvec[2] = '{4'h8, 32'hDEAD_0011, 4'hF, 32'hDEAD_0011};
      rvec[3] = '{4'hC, 32'hBEEF_0011, 4'hF, 32'hBEEF_0011};
      rvec[4] = '{4'h0, 32'h1122_3344, 4'hF, 32'h1122_3344};
      rvec[5] = '{4'h0, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD};
      rvec[6] = '{4'h7, 32'h5566_7788, 4'b0011, 32'hABCD_7788};

      svec[0]  = '{16'h4000, 24'h123456, 24'h123456};
      svec[1]  = '{16'hFFFF, 24'h7FFFFF, 24'h7FFFFF};
      svec[2]  = '{16'hFFFF, 24'h800000, 24'h800000};
      svec[3]  = '{16'h2000, 24'hFFFFFD, 24'hFFFFFE};
      svec[4]  = '{16'h2000, 24'h000005, 24'h000002};
      svec[5]  = '{16'h0000, 24'h123456, 24'h000000};
      svec[6]  = '{16'h8000, 24'h100000, 24'h200000};
      svec[7]  = '{16'h8000, 24'h400000, 24'h7FFFFF};
      svec[8]  = '{16'hC000, 24'hD00000, 24'h800000};
      svec[9]  = '{16'h0001, 24'h7FFFFF, 24'h0001FF};
      svec[10] = '{16'h0001, 24'h800000, 24'hFFFE00};

      tb_ARESETN = 1'b0;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      in_valid = 1'b0; in_ch = '0; in_sample = '0;
      model_reset();
      cycles(3);
      tb_ARESETN = 1'b1;
      cycles(1);

      // Reset state
      @(negedge tb_ACLK);
      check("rst awready", {31'b0, s_axi_awready}, 32'd0);
      check("rst bvalid",  {31'b0, s_axi_bvalid},  32'd0);
      check("rst arready", {31'b0, s_axi_arready}, 32'd0);
      check("rst rvalid",  {31'b0, s_axi_rvalid},  32'd0);
      check("rst rdata",   s_axi_rdata,            32'd0);
      check("rst out_valid", {31'b0, out_valid},   32'd0);
      check("rst out_sample", {8'b0, out_sample},  32'd0);
      @(posedge tb_ACLK);
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
         axi_read(4'(4*k), rd);
         check("rst gain", rd, 32'h0000_4000);
      end

      // Latency 2 at unity gain
      drive_sample(2'd0, 24'h123456, 24'h123456, 1'b0);
      in_valid = 1'b0;
      @(negedge tb_ACLK);
      check("lat1 out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge tb_ACLK);
      #1;
      @(negedge tb_ACLK);
      check("lat2 out_valid", {31'b0, out_valid}, 32'd1);
      check("lat2 out_sample", {8'b0, out_sample}, 32'h0012_3456);
      cycles(1);

      // Register vectors: write then read back
      for (int i = 0; i < 7; i++) begin
         axi_write(rvec[i].addr, rvec[i].wdata, rvec[i].wstrb);
         axi_read(rvec[i].addr, rd);
         check("reg readback", rd, rvec[i].exp_rd);
      end
      for (int k = 0; k < NUM_CH; k++) begin
         axi_read(4'(4*k), rd);
         check("reg final", rd, model_regs[k]);
      end

      // Write back-pressure: BREADY low, second write must wait
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         done = s_axi_awready;
         @(posedge tb_ACLK);
         #1;
      end
      check("bp aw accept", {31'b0, done}, 32'd1);
      model_regs[1] = 32'h0BAD_F00D;
      s_axi_awaddr = 4'h8; s_axi_wdata = 32'h600D_CAFE;
      for (int i = 0; i < 5; i++) begin
         @(negedge tb_ACLK);
         check("bp bvalid held", {31'b0, s_axi_bvalid}, 32'd1);
         check("bp awready blocked", {31'b0, s_axi_awready}, 32'd0);
         @(posedge tb_ACLK);
         #1;
      end
      s_axi_bready = 1'b1;
      cycles(1);
      @(negedge tb_ACLK);
      check("bp second aw ready", {31'b0, s_axi_awready}, 32'd1);
      @(posedge tb_ACLK);
      #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      model_regs[2] = 32'h600D_CAFE;
      @(negedge tb_ACLK);
      check("bp second bvalid", {31'b0, s_axi_bvalid}, 32'd1);
      cycles(1);

      // Read back-pressure: RREADY low, RDATA stable, second read must wait
      s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge tb_ACLK);
         done = s_axi_arready;
         @(posedge tb_ACLK);
         #1;
      end
      check("bp ar accept", {31'b0, done}, 32'd1);
      s_axi_araddr = 4'h8;
      for (int i = 0; i < 5; i++) begin
         @(negedge tb_ACLK);
         check("bp rvalid held", {31'b0, s_axi_rvalid}, 32'd1);
         check("bp rdata stable", s_axi_rdata, model_regs[1]);
         check("bp arready blocked", {31'b0, s_axi_arready}, 32'd0);
         @(posedge tb_ACLK);
         #1;
      end
      s_axi_rready = 1'b1;
      cycles(1);
      @(negedge tb_ACLK);
      check("bp second ar ready", {31'b0, s_axi_arready}, 32'd1);
      @(posedge tb_ACLK);
      #1;
      s_axi_arvalid = 1'b0;
      @(negedge tb_ACLK);
      check("bp second rdata", s_axi_rdata, model_regs[2]);
      cycles(1);

      // Same-cycle write and read of one register returns the old value
      old_val = model_regs[2];
      s_axi_awaddr = 4'h8; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      @(negedge tb_ACLK);
      check("rw awready", {31'b0, s_axi_awready}, 32'd1);
      check("rw arready", {31'b0, s_axi_arready}, 32'd1);
      @(posedge tb_ACLK);
      #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      model_regs[2] = 32'h1234_5678;
      @(negedge tb_ACLK);
      check("rw rdata old", s_axi_rdata, old_val);
      check("rw bvalid", {31'b0, s_axi_bvalid}, 32'd1);
      cycles(1);
      axi_read(4'h8, rd);
      check("rw new value", rd, 32'h1234_5678);

      // Gain/saturation vectors on channel 0
      for (int i = 0; i < 11; i++) begin
         axi_write(4'h0, {16'h0000, svec[i].gain}, 4'hF);
         drive_sample(2'd0, svec[i].sample, svec[i].exp_out, 1'b0);
         in_valid = 1'b0;
         cycles(3);
      end

      // Mid-frame gain write only takes effect on the next frame
      axi_write(4'h0, 32'h0000_4000, 4'hF);
      axi_write(4'h4, 32'h0000_4000, 4'hF);
      axi_write(4'h8, 32'h0000_2000, 4'hF);
      axi_write(4'hC, 32'h0000_8000, 4'hF);
      drive_sample(2'd0, 24'h000100, '0, 1'b1);
      in_valid = 1'b0;
      axi_write(4'h4, 32'h0000_0000, 4'hF);
      drive_sample(2'd1, 24'h000200, 24'h000200, 1'b0);
      drive_sample(2'd2, 24'hFFF000, '0, 1'b1);
      drive_sample(2'd3, 24'h300000, '0, 1'b1);
      drive_sample(2'd0, 24'h0ABCDE, '0, 1'b1);
      drive_sample(2'd1, 24'h000200, 24'h000000, 1'b0);
      drive_sample(2'd2, 24'h7FFFFF, '0, 1'b1);
      drive_sample(2'd3, 24'h800001, '0, 1'b1);
      in_valid = 1'b0;
      cycles(4);
      check("frame drained", sb_q.size(), 32'd0);

      // Reset with BVALID pending and samples in flight
      s_axi_awaddr = 4'hC; s_axi_wdata = 32'h0000_0001; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      cycles(1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      drive_sample(2'd0, 24'h111111, '0, 1'b1);
      drive_sample(2'd1, 24'h222222, '0, 1'b1);
      check("pre-rst bvalid", {31'b0, s_axi_bvalid}, 32'd1);
      #1;
      in_valid = 1'b0;
      tb_ARESETN = 1'b0;
      sb_q.delete();
      model_reset();
      #1;
      check("arst bvalid", {31'b0, s_axi_bvalid}, 32'd0);
      check("arst awready", {31'b0, s_axi_awready}, 32'd0);
      check("arst rvalid", {31'b0, s_axi_rvalid}, 32'd0);
      check("arst rdata", s_axi_rdata, 32'd0);
      check("arst out_valid", {31'b0, out_valid}, 32'd0);
      check("arst out_sample", {8'b0, out_sample}, 32'd0);
      check("arst out_ch", {30'b0, out_ch}, 32'd0);
      s_axi_bready = 1'b1;
      cycles(3);
      tb_ARESETN = 1'b1;
      cycles(3);
      for (int k = 0; k < NUM_CH; k++) begin
         axi_read(4'(4*k), rd);
         check("post-rst gain", rd, 32'h0000_4000);
      end
      drive_sample(2'd2, 24'h0ABCDE, 24'h0ABCDE, 1'b0);
      in_valid = 1'b0;
      cycles(5);
      check("scoreboard drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
